// File: rtl/neuron_layer_sched.sv
// Layer sequencer: time-multiplexes one sequential MAC across NUM_NEURONS outputs,
// fetching each neuron's weights/bias, adding the bias and optionally applying ReLU.
module neuron_layer_sched #(
  parameter int SIZE        = 2,
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = ($clog2(NUM_NEURONS) > 0 ? $clog2(NUM_NEURONS) : 1),
  parameter int TIMEOUT     = SIZE + 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [WIDTH*SIZE-1:0]  inputs,
  output logic                   wt_rd_en,
  output logic [IDX_W-1:0]       wt_addr,
  input  logic [WIDTH*SIZE-1:0]  wt_data,
  input  logic [WIDTH-1:0]       bias_data,
  output logic                   n_start,
  output logic [WIDTH*SIZE-1:0]  n_weights,
  output logic [WIDTH*SIZE-1:0]  n_inputs,
  input  logic [2*WIDTH:0]       n_result,
  input  logic                   n_done,
  output logic                   out_valid,
  output logic [IDX_W-1:0]       out_idx,
  output logic [2*WIDTH+1:0]     out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int RW = 2*WIDTH + 1;
  localparam int OW = 2*WIDTH + 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CW-1:0]    WAIT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_POST  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             relu_r;
  logic [WIDTH-1:0] bias_r;
  logic [CW-1:0]    wait_cnt_r;
  logic             n_done_q_r;
  logic [OW-1:0]    sum_s;
  logic [OW-1:0]    act_s;
  logic             mac_complete_s;

  // Bias add (exact in OW bits), ReLU and rising-edge completion detect
  always_comb begin
    sum_s          = {{(OW-RW){n_result[RW-1]}}, n_result}
                   + {{(OW-WIDTH){bias_r[WIDTH-1]}}, bias_r};
    act_s          = sum_s;
    mac_complete_s = n_done & ~n_done_q_r;
    if (relu_r && sum_s[OW-1]) begin
      act_s = '0;
    end else begin
      act_s = sum_s;
    end
  end

  // Sequencer FSM with all outputs registered on the state transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      relu_r     <= 1'b0;
      bias_r     <= '0;
      wait_cnt_r <= '0;
      n_done_q_r <= 1'b0;
      wt_rd_en   <= 1'b0;
      wt_addr    <= '0;
      n_start    <= 1'b0;
      n_weights  <= '0;
      n_inputs   <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      n_done_q_r <= n_done;
      wt_rd_en   <= 1'b0;
      n_start    <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            n_inputs <= inputs;
            relu_r   <= relu_en;
            idx_r    <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            wt_rd_en <= 1'b1;
            wt_addr  <= '0;
            state_r  <= S_FETCH;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          // Memory data is valid exactly one cycle after the read strobe
          n_weights <= wt_data;
          bias_r    <= bias_data;
          n_start   <= 1'b1;
          state_r   <= S_ISSUE;
        end
        S_ISSUE: begin
          wait_cnt_r <= '0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (mac_complete_s) begin
            out_data  <= act_s;
            out_idx   <= idx_r;
            out_valid <= 1'b1;
            state_r   <= S_POST;
          end else if (wait_cnt_r == WAIT_MAX) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        S_POST: begin
          if (idx_r == LAST_IDX) begin
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            idx_r    <= idx_r + 1'b1;
            wt_rd_en <= 1'b1;
            wt_addr  <= idx_r + 1'b1;
            state_r  <= S_FETCH;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Self-checking bench: behavioural MAC and 1-cycle ROM around the sequencer,
// outputs compared against a dot-product/bias/ReLU reference model.
module tb_neuron_layer_sched;

  localparam int SIZE    = 2;
  localparam int WIDTH   = 8;
  localparam int NN      = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = SIZE + 8;
  localparam int PER_N   = SIZE + 6;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     relu_en;
  logic [WIDTH*SIZE-1:0]    inputs;
  logic                     wt_rd_en;
  logic [IDX_W-1:0]         wt_addr;
  logic [WIDTH*SIZE-1:0]    wt_data;
  logic [WIDTH-1:0]         bias_data;
  logic                     n_start;
  logic [WIDTH*SIZE-1:0]    n_weights;
  logic [WIDTH*SIZE-1:0]    n_inputs;
  logic signed [2*WIDTH:0]  n_result;
  logic                     n_done;
  logic                     out_valid;
  logic [IDX_W-1:0]         out_idx;
  logic signed [2*WIDTH+1:0] out_data;
  logic                     busy;
  logic                     done;
  logic                     err;

  int n_cmp = 0;
  int n_err = 0;
  int rom_w [NN][SIZE];
  int rom_b [NN];
  int in_v  [SIZE];
  bit hang = 1'b0;

  neuron_layer_sched #(
    .SIZE(SIZE), .WIDTH(WIDTH), .NUM_NEURONS(NN), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .inputs(inputs),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data), .bias_data(bias_data),
    .n_start(n_start), .n_weights(n_weights), .n_inputs(n_inputs),
    .n_result(n_result), .n_done(n_done), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous weight/bias memory, one cycle read latency
  always @(posedge clk) begin
    if (wt_rd_en) begin
      for (int k = 0; k < SIZE; k++) wt_data[k*WIDTH +: WIDTH] <= rom_w[wt_addr][k][WIDTH-1:0];
      bias_data <= rom_b[wt_addr][WIDTH-1:0];
    end
  end

  // Sequential MAC: one product per cycle, level done until the next start
  logic             mac_run;
  int               mac_k;
  logic signed [2*WIDTH:0] mac_acc;
  always @(posedge clk) begin
    if (reset) begin
      n_done <= 1'b0; n_result <= '0; mac_run <= 1'b0; mac_k <= 0; mac_acc <= '0;
    end else if (n_start) begin
      n_done <= 1'b0; mac_run <= 1'b1; mac_k <= 0; mac_acc <= '0;
    end else if (mac_run) begin
      if (mac_k == SIZE) begin
        n_done <= !hang; n_result <= mac_acc; mac_run <= 1'b0;
      end else begin
        mac_acc <= mac_acc + $signed(n_inputs[mac_k*WIDTH +: WIDTH]) * $signed(n_weights[mac_k*WIDTH +: WIDTH]);
        mac_k <= mac_k + 1;
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint ref_out(input int j, input bit relu);
    longint s = rom_b[j];
    for (int k = 0; k < SIZE; k++) s += longint'(in_v[k]) * longint'(rom_w[j][k]);
    return (relu && s < 0) ? 0 : s;
  endfunction

  task automatic set_neuron(input int j, input int w0, input int w1, input int b);
    rom_w[j][0] = w0; rom_w[j][1] = w1; rom_b[j] = b;
  endtask

  task automatic randomize_all();
    for (int j = 0; j < NN; j++) begin
      for (int k = 0; k < SIZE; k++) rom_w[j][k] = int'($urandom_range(255)) - 128;
      rom_b[j] = int'($urandom_range(255)) - 128;
    end
    for (int k = 0; k < SIZE; k++) in_v[k] = int'($urandom_range(255)) - 128;
  endtask

  // One layer pass starting at a negedge; returns in the IDLE cycle after done
  task automatic run_pass(input bit relu, input bit mid_start, input bit expect_to);
    int  np = 0;
    bit  got_done = 1'b0;
    for (int k = 0; k < SIZE; k++) inputs[k*WIDTH +: WIDTH] = in_v[k][WIDTH-1:0];
    relu_en = relu;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    relu_en = ~relu;
    inputs  = WIDTH*SIZE'($urandom);
    check("busy_after_accept", busy, 1);
    check("err_cleared", err, 0);
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (out_valid) begin
        check("valid_cycle", c, np*PER_N + SIZE + 5);
        if (np < NN) begin
          check("out_idx", out_idx, np);
          check("out_data", out_data, ref_out(np, relu));
        end
        np++;
      end
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", c, expect_to ? TIMEOUT + 3 : NN*PER_N);
        check("err_at_done", err, expect_to);
        check("busy_at_done", busy, 1);
      end
      start = (mid_start && c == 10);
      if (start) inputs = WIDTH*SIZE'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("valid_count", np, expect_to ? 0 : NN);
    check("busy_idle", busy, 0);
    check("done_single", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; inputs = '0;
    for (int j = 0; j < NN; j++) set_neuron(j, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_en", wt_rd_en, 0);
    check("rst_n_start", n_start, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic pass and ReLU with the directed vectors
    in_v[0] = 2; in_v[1] = 3;
    set_neuron(0, 1, 1, 0); set_neuron(1, 2, -1, 10);
    set_neuron(2, 0, 4, -3); set_neuron(3, -1, -1, 0);
    check("ref_sanity_n1", ref_out(1, 1'b0), 11);
    run_pass(1'b0, 1'b0, 1'b0);
    run_pass(1'b1, 1'b0, 1'b0);

    // Extremes, back-to-back with the previous pass
    in_v[0] = -128; in_v[1] = -128;
    for (int j = 0; j < NN; j++) set_neuron(j, -128, -128, 127);
    run_pass(1'b1, 1'b0, 1'b0);

    // Random back-to-back passes, some with a start pulse mid-pass
    for (int r = 0; r < 6; r++) begin
      randomize_all();
      run_pass(1'(($urandom & 32'd1)), 1'(r[0]), 1'b0);
    end

    // Hung MAC: timeout, err sticky until next accepted start
    hang = 1'b1;
    randomize_all();
    run_pass(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);
    hang = 1'b0;
    run_pass(1'b0, 1'b0, 1'b0);

    // Reset while neuron 2 is in WAIT
    randomize_all();
    for (int k = 0; k < SIZE; k++) inputs[k*WIDTH +: WIDTH] = in_v[k][WIDTH-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_n_start", n_start, 0);
    check("mid_rst_rd_en", wt_rd_en, 0);
    check("mid_rst_err", err, 0);
    begin
      int ev = 0;
      for (int c = 0; c < 40; c++) begin
        if (out_valid || done) ev++;
        @(negedge clk);
      end
      check("post_rst_quiet", ev, 0);
    end
    run_pass(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
